// File: rtl/regf_wb_arb_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Register geometry and the fixed requester slot assignment.
package regf_wb_arb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned WB_ALU  = 0;
  localparam int unsigned WB_LSU  = 1;
  localparam int unsigned WB_MUL  = 2;
  localparam int unsigned WB_NREQ = 3;

  // Pointer width for an n-way arbiter; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regf_wb_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at NREQ.
// Purely combinational so it can front any shared single-port resource.
module rr_arbiter
  import regf_wb_arb_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ
) (
  input  logic [NREQ-1:0]        req,
  input  logic [ptr_w(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        gnt,
  output logic [ptr_w(NREQ)-1:0] idx
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [PW:0] cand;
  logic        found;

  // Wrap is an explicit compare-and-subtract so non-power-of-two NREQ works.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!found && req[cand[PW-1:0]]) begin
        found             = 1'b1;
        gnt[cand[PW-1:0]] = 1'b1;
        idx               = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/regf_wb_arb.sv
// Write-back arbiter for the register file's single write port.
// Round-robin accept, one-cycle registered write stage, decode-side RAW hazard flags.
module regf_wb_arb
  import regf_wb_arb_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned DW   = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_waddr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  input  logic [AW-1:0]        raddr0,
  input  logic [AW-1:0]        raddr1,
  output logic                 hazard0,
  output logic                 hazard1
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            out_vld_q, out_vld_d;
  logic [AW-1:0]   out_addr_q, out_addr_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            xfer;
  logic            hit0, hit1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Winner payload mux and reset-gated handshake.
  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = req_waddr[i*AW +: AW];
        sel_data = req_wdata[i*DW +: DW];
      end
    end
    req_ready = rst ? '0 : arb_gnt;
    xfer      = |req_ready;
  end

  // Next state: x0 targets are accepted but never raise we.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    out_vld_d  = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    if (xfer) begin
      rr_ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
      out_vld_d  = (sel_addr != '0);
      out_addr_d = sel_addr;
      out_data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign we    = out_vld_q;
  assign waddr = out_addr_q;
  assign wdata = out_data_q;

  // A read is hazardous while its register is queued or in the write stage.
  always_comb begin
    hit0 = out_vld_q && (out_addr_q == raddr0);
    hit1 = out_vld_q && (out_addr_q == raddr1);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (req_waddr[i*AW +: AW] == raddr0)) hit0 = 1'b1;
      if (req_valid[i] && (req_waddr[i*AW +: AW] == raddr1)) hit1 = 1'b1;
    end
    hazard0 = (raddr0 != '0) && hit0;
    hazard1 = (raddr1 != '0) && hit1;
  end

endmodule
